// File: rtl/seq_gen.sv
// Serial frame generator: emits preamble, latched payload and idle-high gap on dout.
// Outputs are registered; busy spans the frame bits and done pulses once after the gap.
module seq_gen #(
  parameter int unsigned PRE_W    = 8,
  parameter logic [PRE_W-1:0] PREAMBLE = 8'b0101_0101,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned GAP      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MAX_PD = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int unsigned MAX_W  = (MAX_PD > GAP) ? MAX_PD : GAP;
  localparam int unsigned CNT_W  = $clog2(MAX_W + 1);
  localparam int unsigned SR_W   = PRE_W + DATA_W;

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_PAY, ST_GAP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [SR_W-1:0]   sr, sr_n;
  logic              dout_n, busy_n, done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sr    <= '0;
      dout  <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sr    <= sr_n;
      dout  <= dout_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Outputs are computed for the bit shown next cycle, so the preamble MSB
  // goes out directly at acceptance and the shift register holds the rest.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    dout_n  = 1'b1;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_PRE;
          cnt_n   = CNT_W'(PRE_W - 1);
          sr_n    = {PREAMBLE, data} << 1;
          dout_n  = PREAMBLE[PRE_W-1];
          busy_n  = 1'b1;
        end
      end
      ST_PRE: begin
        busy_n = 1'b1;
        dout_n = sr[SR_W-1];
        sr_n   = sr << 1;
        if (cnt == '0) begin
          state_n = ST_PAY;
          cnt_n   = CNT_W'(DATA_W - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_PAY: begin
        busy_n = 1'b1;
        if (cnt == '0) begin
          state_n = ST_GAP;
          cnt_n   = CNT_W'(GAP - 1);
        end else begin
          dout_n = sr[SR_W-1];
          sr_n   = sr << 1;
          cnt_n  = cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          busy_n = 1'b1;
          cnt_n  = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule
